// File: rtl/memory_access_arbiter.sv
// Arbitrates fetch and load/store requesters onto one memory bus.
// Aligned accesses run a bus cycle; misaligned or stalled ones return err.
module memory_access_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_rw,
  input  logic        ls_sign,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        ls_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic        mem_sign,
  output logic [3:0]  mem_byte_en,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, BUS_IF, BUS_LS, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_done_q, if_done_d;
  logic        if_err_q, if_err_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        ls_done_q, ls_done_d;
  logic        ls_err_q, ls_err_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic        sign_q, sign_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d;

  logic        gnt_ls, gnt_if, g_rw, g_sign, g_mis;
  logic [1:0]  g_size;
  logic [31:0] g_addr;
  logic [3:0]  g_be;
  logic [7:0]  cnt_inc;

  function automatic logic misaligned(input logic [1:0] sz,
                                      input logic [1:0] lo);
    unique case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz,
                                         input logic [1:0] lo);
    unique case (sz)
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // On a tie the requester not served last wins
  assign gnt_ls  = ls_req & (~if_req | ~last_q);
  assign gnt_if  = if_req & ~gnt_ls;
  assign g_addr  = gnt_ls ? ls_addr : if_addr;
  assign g_size  = gnt_ls ? ls_size : 2'b10;
  assign g_rw    = gnt_ls & ls_rw;
  assign g_sign  = gnt_ls & ls_sign;
  assign g_mis   = misaligned(g_size, g_addr[1:0]);
  assign g_be    = byte_en(g_size, g_addr[1:0]);
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    ls_done_d  = 1'b0;
    ls_err_d   = 1'b0;
    valid_d    = valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    sign_d     = sign_q;
    be_d       = be_q;
    size_d     = size_q;
    case (state_q)
      IDLE: begin
        if (gnt_if || gnt_ls) begin
          last_d = gnt_ls;
          cnt_d  = 8'd0;
          if (g_mis) begin
            state_d   = RESP;
            if_done_d = gnt_if;
            if_err_d  = gnt_if;
            ls_done_d = gnt_ls;
            ls_err_d  = gnt_ls;
          end else begin
            state_d = gnt_ls ? BUS_LS : BUS_IF;
            valid_d = 1'b1;
            addr_d  = {g_addr[31:2], 2'b00};
            wdata_d = (gnt_ls && ls_rw) ? ls_wdata : 32'd0;
            rw_d    = g_rw;
            sign_d  = g_sign;
            be_d    = g_be;
            size_d  = g_size;
          end
        end
      end
      BUS_IF, BUS_LS: begin
        if (mem_ready || cnt_inc == 8'(TIMEOUT)) begin
          state_d = RESP;
          valid_d = 1'b0;
          rw_d    = 1'b0;
          sign_d  = 1'b0;
          be_d    = 4'b0000;
          size_d  = 2'b00;
          if (state_q == BUS_IF) begin
            if_done_d = 1'b1;
            if_err_d  = ~mem_ready;
            if (mem_ready) if_rdata_d = mem_rdata;
          end else begin
            ls_done_d = 1'b1;
            ls_err_d  = ~mem_ready;
            if (mem_ready) ls_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      last_q     <= 1'b0;
      if_rdata_q <= 32'd0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      ls_rdata_q <= 32'd0;
      ls_done_q  <= 1'b0;
      ls_err_q   <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rw_q       <= 1'b0;
      sign_q     <= 1'b0;
      be_q       <= 4'b0000;
      size_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      if_rdata_q <= if_rdata_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      ls_rdata_q <= ls_rdata_d;
      ls_done_q  <= ls_done_d;
      ls_err_q   <= ls_err_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      sign_q     <= sign_d;
      be_q       <= be_d;
      size_q     <= size_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_done     = if_done_q;
  assign if_err      = if_err_q;
  assign ls_rdata    = ls_rdata_q;
  assign ls_done     = ls_done_q;
  assign ls_err      = ls_err_q;
  assign mem_valid   = valid_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_rw      = rw_q;
  assign mem_sign    = sign_q;
  assign mem_byte_en = be_q;
  assign mem_size    = size_q;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter: arbitration, alignment,
// wait states, timeout and mid-transfer reset.
module tb_memory_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done, if_err;
  logic        ls_req, ls_rw, ls_sign;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        ls_done, ls_err;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw, mem_sign;
  logic [3:0]  mem_byte_en;
  logic [1:0]  mem_size;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt;
  int done_at;
  logic err_seen;

  memory_access_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_err(if_err),
    .ls_req(ls_req), .ls_rw(ls_rw), .ls_sign(ls_sign),
    .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_sign(mem_sign), .mem_byte_en(mem_byte_en),
    .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0;
    ls_req = 0; ls_rw = 0; ls_sign = 0; ls_size = 0;
    ls_addr = 0; ls_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    tick;
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    rst = 1'b0;
    tick;

    // tie after reset goes to load/store, then fetch
    if_req = 1; if_addr = 32'h40;
    ls_req = 1; ls_rw = 0; ls_size = 2'b10; ls_addr = 32'h100;
    ls_wdata = 32'h5555_5555;
    mem_ready = 1; mem_rdata = 32'h1122_3344;
    tick;
    chk("tie_valid", mem_valid, 1);
    chk("tie_addr", mem_addr, 32'h100);
    chk("tie_be", mem_byte_en, 4'hF);
    chk("tie_rw", mem_rw, 0);
    chk("tie_wdata", mem_wdata, 0);
    tick;
    chk("tie_ls_done", ls_done, 1);
    chk("tie_ls_err", ls_err, 0);
    chk("tie_ls_rdata", ls_rdata, 32'h1122_3344);
    chk("tie_if_done0", if_done, 0);
    chk("tie_valid_resp", mem_valid, 0);
    ls_req = 0; mem_rdata = 32'hCAFE_F00D;
    tick;
    chk("idle_valid", mem_valid, 0);
    chk("idle_ls_done", ls_done, 0);
    tick;
    chk("if_valid", mem_valid, 1);
    chk("if_addr", mem_addr, 32'h40);
    chk("if_size", mem_size, 2'b10);
    tick;
    chk("if_done", if_done, 1);
    chk("if_err", if_err, 0);
    chk("if_rdata", if_rdata, 32'hCAFE_F00D);
    if_req = 0; mem_ready = 0;
    tick;

    // byte write at 0x203
    ls_req = 1; ls_rw = 1; ls_size = 2'b00; ls_addr = 32'h203;
    ls_wdata = 32'hAB;
    tick;
    chk("bw_valid", mem_valid, 1);
    chk("bw_addr", mem_addr, 32'h200);
    chk("bw_be", mem_byte_en, 4'b1000);
    chk("bw_size", mem_size, 2'b00);
    chk("bw_rw", mem_rw, 1);
    chk("bw_wdata", mem_wdata, 32'hAB);
    mem_ready = 1;
    tick;
    chk("bw_done", ls_done, 1);
    chk("bw_err", ls_err, 0);
    chk("bw_be_resp", mem_byte_en, 0);
    chk("bw_rw_resp", mem_rw, 0);
    ls_req = 0; mem_ready = 0;
    tick;

    // misaligned half and fetch
    ls_req = 1; ls_rw = 0; ls_size = 2'b01; ls_addr = 32'h11;
    tick;
    chk("mh_done", ls_done, 1);
    chk("mh_err", ls_err, 1);
    chk("mh_valid", mem_valid, 0);
    ls_req = 0;
    tick;
    chk("mh_done_once", ls_done, 0);
    chk("mh_err_once", ls_err, 0);
    if_req = 1; if_addr = 32'h2;
    tick;
    chk("mf_done", if_done, 1);
    chk("mf_err", if_err, 1);
    chk("mf_valid", mem_valid, 0);
    if_req = 0;
    tick;
    chk("mf_done_once", if_done, 0);

    // fetch timeout
    if_req = 1; if_addr = 32'h40; mem_ready = 0;
    vcnt = 0; done_at = -1; err_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (mem_valid) vcnt++;
      if (if_done && done_at < 0) begin
        done_at = i; err_seen = if_err; if_req = 0;
      end
    end
    chk("to_valid_cycles", vcnt, 15);
    chk("to_done_at", done_at, 15);
    chk("to_err", err_seen, 1);
    chk("to_rdata_keep", if_rdata, 32'hCAFE_F00D);
    chk("to_valid_after", mem_valid, 0);

    // wait states with stable bus
    if_req = 1; if_addr = 32'h80; mem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("ws_valid", mem_valid, 1);
      chk("ws_addr", mem_addr, 32'h80);
      chk("ws_be", mem_byte_en, 4'hF);
      chk("ws_size", mem_size, 2'b10);
    end
    mem_ready = 1;
    tick;
    chk("ws_done", if_done, 1);
    chk("ws_err", if_err, 0);
    chk("ws_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 0; mem_ready = 0;
    tick;

    // ready on the same edge the count hits TIMEOUT
    if_req = 1; if_addr = 32'h84; mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 14; k++) tick;
    tick;
    chk("edge_valid", mem_valid, 1);
    chk("edge_done0", if_done, 0);
    mem_ready = 1;
    tick;
    chk("edge_done", if_done, 1);
    chk("edge_err", if_err, 0);
    chk("edge_rdata", if_rdata, 32'h1234_5678);
    if_req = 0; mem_ready = 0;
    tick;

    // reset mid-transfer
    ls_req = 1; ls_rw = 0; ls_size = 2'b10; ls_addr = 32'h300;
    tick;
    chk("rb_valid", mem_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_valid", mem_valid, 0);
    chk("rr_addr", mem_addr, 0);
    chk("rr_if_rdata", if_rdata, 0);
    chk("rr_ls_done", ls_done, 0);
    ls_req = 0;
    tick;
    rst = 1'b0;
    tick;
    chk("ra_ls_done", ls_done, 0);
    chk("ra_valid", mem_valid, 0);
    if_req = 1; if_addr = 32'h44;
    ls_req = 1; ls_addr = 32'h104;
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    tick;
    chk("ra_tie_addr", mem_addr, 32'h104);
    tick;
    chk("ra_ls_done1", ls_done, 1);
    chk("ra_ls_rdata", ls_rdata, 32'h0BAD_F00D);
    chk("ra_if_done0", if_done, 0);
    ls_req = 0;
    tick;
    tick;
    chk("ra_if_addr", mem_addr, 32'h44);
    tick;
    chk("ra_if_done", if_done, 1);
    if_req = 0; mem_ready = 0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
